// File: rtl/sum_acc_pkg.sv
// Shared state encoding and default widths for the {cout,sum} accumulator slice.
package sum_acc_pkg;

  localparam int IN_W_DEF  = 4;
  localparam int ACC_W_DEF = 12;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sum_accumulator_if.sv
// Sample stream from the ripple adder: {cout,sum} with a valid/ready handshake.
interface sum_accumulator_if
  import sum_acc_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) ();

  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] sum;
  logic            cout;

  modport master (output in_valid, output sum, output cout, input in_ready);
  modport slave  (input in_valid, input sum, input cout, output in_ready);

endinterface

// File: rtl/sum_accumulator_sat_add.sv
// W-bit saturating adder: y clamps to all-ones and sat rises when the carry out of bit W-1 is set.
module sat_add
  import sum_acc_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         sat
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    sat  = full[W];
    y    = full[W] ? {W{1'b1}} : full[W-1:0];
  end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a programmed number of adder results into a saturating register and
// reports busy/done/overflow to the controller.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 start,
  input  logic [CNT_W-1:0]     len,
  sum_accumulator_if.slave     s_if,
  output logic [ACC_W-1:0]     acc,
  output logic [CNT_W-1:0]     count,
  output logic                 ovf,
  output logic                 busy,
  output logic                 done
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   count_q, count_d, count_inc;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   sample, add_y;
  logic               add_sat;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept, last;

  assign s_if.in_ready = (state_q == ST_ACCUM);
  assign accept        = s_if.in_valid && s_if.in_ready;
  assign sample        = ACC_W'({s_if.cout, s_if.sum});
  assign count_inc     = count_q + 1'b1;
  assign last          = (count_inc == len_q);

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc_q),
    .b   (sample),
    .y   (add_y),
    .sat (add_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // clr dominates start and accept in every state.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_d = (len == '0) ? ST_DONE : ST_ACCUM;
        end
        ST_ACCUM: begin
          if (accept && last) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered status flags follow the state being entered.
  always_comb begin
    busy_d = (state_d == ST_ACCUM);
    done_d = (state_d == ST_DONE);
  end

  always_comb begin
    len_d   = len_q;
    count_d = count_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      len_d   = len;
      count_d = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      count_d = count_inc;
      acc_d   = add_y;
      ovf_d   = ovf_q | add_sat;
    end
  end

  assign acc   = acc_q;
  assign count = count_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench: a 12-bit accumulator for the functional runs and an 8-bit one for saturation.
module tb_sum_accumulator;
  import sum_acc_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic        a_clr, a_start;
  logic [3:0]  a_len;
  logic [11:0] a_acc;
  logic [3:0]  a_count;
  logic        a_ovf, a_busy, a_done;

  logic        b_clr, b_start;
  logic [3:0]  b_len;
  logic [7:0]  b_acc;
  logic [3:0]  b_count;
  logic        b_ovf, b_busy, b_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] vec_s   [5] = '{5'd1, 5'd2, 5'd3, 5'd9, 5'd25};
  int         vec_acc [5] = '{1, 3, 6, 15, 40};

  sum_accumulator_if #(.IN_W(4)) a_if ();
  sum_accumulator_if #(.IN_W(4)) b_if ();

  sum_accumulator #(.IN_W(4), .ACC_W(12), .CNT_W(4)) dut (
    .clk (clk), .rst (rst), .clr (a_clr), .start (a_start), .len (a_len),
    .s_if (a_if), .acc (a_acc), .count (a_count), .ovf (a_ovf),
    .busy (a_busy), .done (a_done)
  );

  sum_accumulator #(.IN_W(4), .ACC_W(8), .CNT_W(4)) dut8 (
    .clk (clk), .rst (rst), .clr (b_clr), .start (b_start), .len (b_len),
    .s_if (b_if), .acc (b_acc), .count (b_count), .ovf (b_ovf),
    .busy (b_busy), .done (b_done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] s);
    a_if.in_valid = v;
    a_if.sum      = s[3:0];
    a_if.cout     = s[4];
    cyc();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    a_clr = 0; a_start = 0; a_len = 0;
    a_if.in_valid = 0; a_if.sum = 0; a_if.cout = 0;
    b_clr = 0; b_start = 0; b_len = 0;
    b_if.in_valid = 0; b_if.sum = 0; b_if.cout = 0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_acc", 32'(a_acc), 0);
    checkOutput("rst_count", 32'(a_count), 0);
    checkOutput("rst_ovf", 32'(a_ovf), 0);
    checkOutput("rst_busy", 32'(a_busy), 0);
    checkOutput("rst_done", 32'(a_done), 0);
    checkOutput("rst_ready", 32'(a_if.in_ready), 0);
    checkOutput("rst_b_acc", 32'(b_acc), 0);
    cyc();
    rst = 1'b0;
    cyc();

    $display("[TB] adder vector run len=5");
    a_start = 1; a_len = 5;
    cyc();
    a_start = 0;
    checkOutput("run_busy", 32'(a_busy), 1);
    checkOutput("run_ready", 32'(a_if.in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, vec_s[i]);
      checkOutput("run_acc", 32'(a_acc), 32'(vec_acc[i]));
      checkOutput("run_count", 32'(a_count), 32'(i + 1));
    end
    checkOutput("run_done", 32'(a_done), 1);
    checkOutput("run_ovf", 32'(a_ovf), 0);
    checkOutput("run_ready_done", 32'(a_if.in_ready), 0);
    applyStimulus(1'b0, 5'd0);
    checkOutput("run_done_pulse", 32'(a_done), 0);
    checkOutput("run_acc_hold", 32'(a_acc), 40);
    checkOutput("run_idle_busy", 32'(a_busy), 0);

    $display("[TB] bubble run len=5");
    a_start = 1; a_len = 5;
    cyc();
    a_start = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 5'd31);
      checkOutput("bub_count_hold", 32'(a_count), 32'(i));
      applyStimulus(1'b1, vec_s[i]);
      checkOutput("bub_acc", 32'(a_acc), 32'(vec_acc[i]));
    end
    checkOutput("bub_done", 32'(a_done), 1);
    checkOutput("bub_count", 32'(a_count), 5);
    applyStimulus(1'b0, 5'd0);

    $display("[TB] zero-length run");
    a_start = 1; a_len = 0;
    cyc();
    checkOutput("len0_done", 32'(a_done), 1);
    checkOutput("len0_acc", 32'(a_acc), 0);
    checkOutput("len0_ready", 32'(a_if.in_ready), 0);
    a_len = 5;
    cyc();
    checkOutput("len0_done_pulse", 32'(a_done), 0);
    checkOutput("len0_start_ignored", 32'(a_busy), 0);
    checkOutput("len0_ready2", 32'(a_if.in_ready), 0);
    a_start = 0;
    cyc();

    $display("[TB] clr with start and accept");
    a_start = 1; a_len = 5;
    cyc();
    a_start = 0;
    applyStimulus(1'b1, 5'd3);
    applyStimulus(1'b1, 5'd4);
    checkOutput("clr_pre_count", 32'(a_count), 2);
    checkOutput("clr_pre_acc", 32'(a_acc), 7);
    a_clr = 1; a_start = 1;
    applyStimulus(1'b1, 5'd10);
    checkOutput("clr_acc", 32'(a_acc), 0);
    checkOutput("clr_count", 32'(a_count), 0);
    checkOutput("clr_busy", 32'(a_busy), 0);
    checkOutput("clr_done", 32'(a_done), 0);
    a_clr = 0; a_start = 0;
    applyStimulus(1'b1, 5'd10);
    checkOutput("clr_stay_idle", 32'(a_busy), 0);
    checkOutput("clr_no_accept", 32'(a_acc), 0);
    applyStimulus(1'b0, 5'd0);

    $display("[TB] async reset mid-run");
    a_start = 1; a_len = 5;
    cyc();
    a_start = 0;
    applyStimulus(1'b1, 5'd1);
    applyStimulus(1'b1, 5'd1);
    applyStimulus(1'b1, 5'd1);
    checkOutput("mid_count", 32'(a_count), 3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_acc", 32'(a_acc), 0);
    checkOutput("mid_rst_count", 32'(a_count), 0);
    checkOutput("mid_rst_busy", 32'(a_busy), 0);
    checkOutput("mid_rst_ready", 32'(a_if.in_ready), 0);
    a_if.in_valid = 0;
    cyc();
    rst = 1'b0;
    cyc();

    $display("[TB] saturation ACC_W=8 len=15");
    b_start = 1; b_len = 15;
    cyc();
    b_start = 0;
    b_if.in_valid = 1; b_if.sum = 4'hF; b_if.cout = 1;
    for (int k = 0; k < 8; k++) cyc();
    checkOutput("sat_acc8", 32'(b_acc), 248);
    checkOutput("sat_ovf8", 32'(b_ovf), 0);
    cyc();
    checkOutput("sat_acc9", 32'(b_acc), 255);
    checkOutput("sat_ovf9", 32'(b_ovf), 1);
    for (int k = 0; k < 6; k++) cyc();
    checkOutput("sat_done", 32'(b_done), 1);
    checkOutput("sat_count", 32'(b_count), 15);
    checkOutput("sat_acc15", 32'(b_acc), 255);
    b_if.in_valid = 0;
    cyc();
    checkOutput("sat_acc_hold", 32'(b_acc), 255);
    checkOutput("sat_ovf_hold", 32'(b_ovf), 1);
    checkOutput("sat_done_pulse", 32'(b_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
